match_controller: RTL and testbench

//  Pong match sequencer. Owns game flow: idle, serve, rally, point delay, pause, game over.

---
 rtl/match_controller.sv | 183 ++++++++++++++++++
 tb/tb_match_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Pong match sequencer: game-flow FSM, BCD scores for both players, frame-based
// point/game-over delay and serve alternation.
module match_controller #(
    parameter int WIN_SCORE    = 5,
    parameter int DELAY_FRAMES = 120,
    parameter int TIMER_W      = 8
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic [2:0] state,
    output logic       gra_still,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] p1_dig1,
    output logic [3:0] p1_dig0,
    output logic [3:0] p2_dig1,
    output logic [3:0] p2_dig0,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        PAUSE = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(DELAY_FRAMES - 1);
    // The game-over timer parks one past the last tick so "delay elapsed" is a single compare.
    localparam logic [TIMER_W-1:0] DONE_TICK = TIMER_W'(DELAY_FRAMES);

    state_t             state_reg, state_next;
    logic [7:0]         p1_reg, p1_next, p2_reg, p2_next;
    logic [1:0]         winner_reg, winner_next;
    logic               serve_dir_reg, serve_dir_next;
    logic               ball_reset_reg, ball_reset_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic               start_q, pause_q, missl_q, missr_q;

    logic       start_e, pause_e, missl_e, missr_e;
    logic [7:0] p1_inc, p2_inc;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign start_e = start_btn & ~start_q;
    assign pause_e = pause_btn & ~pause_q;
    assign missl_e = miss_l & ~missl_q;
    assign missr_e = miss_r & ~missr_q;
    assign p1_inc  = bcd_inc(p1_reg);
    assign p2_inc  = bcd_inc(p2_reg);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            p1_reg         <= '0;
            p2_reg         <= '0;
            winner_reg     <= '0;
            serve_dir_reg  <= 1'b0;
            ball_reset_reg <= 1'b0;
            timer_reg      <= '0;
            start_q        <= 1'b0;
            pause_q        <= 1'b0;
            missl_q        <= 1'b0;
            missr_q        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            p1_reg         <= p1_next;
            p2_reg         <= p2_next;
            winner_reg     <= winner_next;
            serve_dir_reg  <= serve_dir_next;
            ball_reset_reg <= ball_reset_next;
            timer_reg      <= timer_next;
            start_q        <= start_btn;
            pause_q        <= pause_btn;
            missl_q        <= miss_l;
            missr_q        <= miss_r;
        end
    end

    always_comb begin
        state_next      = state_reg;
        p1_next         = p1_reg;
        p2_next         = p2_reg;
        winner_next     = winner_reg;
        serve_dir_next  = serve_dir_reg;
        ball_reset_next = 1'b0;
        timer_next      = timer_reg;
        case (state_reg)
            IDLE: begin
                p1_next     = '0;
                p2_next     = '0;
                winner_next = '0;
                timer_next  = '0;
                if (start_e)
                    state_next = SERVE;
            end
            SERVE: begin
                if (start_e) begin
                    state_next      = PLAY;
                    ball_reset_next = 1'b1;
                end
            end
            PLAY: begin
                // Simultaneous misses cancel; any miss edge outranks a pause request.
                if (missl_e && !missr_e) begin
                    p2_next        = p2_inc;
                    serve_dir_next = 1'b0;
                    timer_next     = '0;
                    if (p2_inc == WIN_BCD) begin
                        state_next  = OVER;
                        winner_next = 2'b10;
                    end else begin
                        state_next = POINT;
                    end
                end else if (missr_e && !missl_e) begin
                    p1_next        = p1_inc;
                    serve_dir_next = 1'b1;
                    timer_next     = '0;
                    if (p1_inc == WIN_BCD) begin
                        state_next  = OVER;
                        winner_next = 2'b01;
                    end else begin
                        state_next = POINT;
                    end
                end else if (!missl_e && !missr_e && pause_e) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_e)
                    state_next = PLAY;
            end
            POINT: begin
                if (frame_tick) begin
                    if (timer_reg == LAST_TICK) begin
                        state_next = SERVE;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end
            OVER: begin
                if (start_e && timer_reg == DONE_TICK) begin
                    state_next  = IDLE;
                    p1_next     = '0;
                    p2_next     = '0;
                    winner_next = '0;
                    timer_next  = '0;
                end else if (frame_tick && timer_reg != DONE_TICK) begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state      = state_reg;
    assign gra_still  = (state_reg != PLAY);
    assign ball_reset = ball_reset_reg;
    assign serve_dir  = serve_dir_reg;
    assign p1_dig1    = p1_reg[7:4];
    assign p1_dig0    = p1_reg[3:0];
    assign p2_dig1    = p2_reg[7:4];
    assign p2_dig0    = p2_reg[3:0];
    assign winner     = winner_reg;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: two instances (short and long matches) driven by shared
// directed then random stimulus, compared every cycle against an integer-score game model.
module tb_match_controller;

    logic clk = 1'b0;
    logic reset, frame_tick, start_btn, pause_btn, miss_l, miss_r;

    logic [2:0] st [2];
    logic       gs [2];
    logic       br [2];
    logic       sd [2];
    logic [3:0] a1 [2];
    logic [3:0] a0 [2];
    logic [3:0] b1 [2];
    logic [3:0] b0 [2];
    logic [1:0] wn [2];

    int checks = 0;
    int failures = 0;

    localparam int WIN0 = 5, DLY0 = 120;
    localparam int WIN1 = 99, DLY1 = 3;
    int win_lim [2] = '{WIN0, WIN1};
    int dly     [2] = '{DLY0, DLY1};

    // Model: 0 idle, 1 serve, 2 play, 3 point, 4 pause, 5 over
    int m_mode [2];
    int m_p1 [2];
    int m_p2 [2];
    int m_ticks [2];
    int m_winner [2];
    bit m_sd [2];
    bit m_br [2];
    bit q_start, q_pause, q_ml, q_mr;

    always #5 clk = ~clk;

    match_controller #(.WIN_SCORE(WIN0), .DELAY_FRAMES(DLY0), .TIMER_W(8)) dut0 (
        .clk_100MHz(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .pause_btn(pause_btn), .miss_l(miss_l), .miss_r(miss_r), .state(st[0]),
        .gra_still(gs[0]), .ball_reset(br[0]), .serve_dir(sd[0]), .p1_dig1(a1[0]),
        .p1_dig0(a0[0]), .p2_dig1(b1[0]), .p2_dig0(b0[0]), .winner(wn[0])
    );

    match_controller #(.WIN_SCORE(WIN1), .DELAY_FRAMES(DLY1), .TIMER_W(4)) dut1 (
        .clk_100MHz(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .pause_btn(pause_btn), .miss_l(miss_l), .miss_r(miss_r), .state(st[1]),
        .gra_still(gs[1]), .ball_reset(br[1]), .serve_dir(sd[1]), .p1_dig1(a1[1]),
        .p1_dig0(a0[1]), .p2_dig1(b1[1]), .p2_dig0(b0[1]), .winner(wn[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_p1[k] = 0; m_p2[k] = 0; m_ticks[k] = 0;
            m_winner[k] = 0; m_sd[k] = 0; m_br[k] = 0;
        end
        q_start = 0; q_pause = 0; q_ml = 0; q_mr = 0;
    endtask

    task automatic model_step(input int k);
        bit se, pe, ml, mr;
        int s;
        se = start_btn && !q_start;
        pe = pause_btn && !q_pause;
        ml = miss_l && !q_ml;
        mr = miss_r && !q_mr;
        m_br[k] = 0;
        case (m_mode[k])
            0: if (se) m_mode[k] = 1;
            1: if (se) begin m_mode[k] = 2; m_br[k] = 1; end
            2: begin
                if (ml != mr) begin
                    if (ml) begin
                        m_p2[k] = (m_p2[k] < 99) ? m_p2[k] + 1 : 99;
                        m_sd[k] = 0; s = m_p2[k];
                    end else begin
                        m_p1[k] = (m_p1[k] < 99) ? m_p1[k] + 1 : 99;
                        m_sd[k] = 1; s = m_p1[k];
                    end
                    m_ticks[k] = 0;
                    if (s == win_lim[k]) begin
                        m_mode[k] = 5; m_winner[k] = ml ? 2 : 1;
                    end else begin
                        m_mode[k] = 3;
                    end
                end else if (!ml && !mr && pe) begin
                    m_mode[k] = 4;
                end
            end
            3: if (frame_tick) begin
                m_ticks[k]++;
                if (m_ticks[k] == dly[k]) begin m_mode[k] = 1; m_ticks[k] = 0; end
            end
            4: if (pe) m_mode[k] = 2;
            5: begin
                if (se && m_ticks[k] == dly[k]) begin
                    m_mode[k] = 0; m_p1[k] = 0; m_p2[k] = 0; m_winner[k] = 0; m_ticks[k] = 0;
                end else if (frame_tick && m_ticks[k] < dly[k]) begin
                    m_ticks[k]++;
                end
            end
            default: m_mode[k] = 0;
        endcase
    endtask

    function automatic logic [23:0] exp_vec(input int k);
        return {3'(m_mode[k]), m_mode[k] != 2, m_br[k], m_sd[k],
                4'(m_p1[k] / 10), 4'(m_p1[k] % 10), 4'(m_p2[k] / 10), 4'(m_p2[k] % 10),
                2'(m_winner[k])};
    endfunction

    function automatic logic [23:0] got_vec(input int k);
        return {st[k], gs[k], br[k], sd[k], a1[k], a0[k], b1[k], b0[k], wn[k]};
    endfunction

    // One clock: advance the model with the inputs the DUT sees at this edge, then compare.
    task automatic tick();
        model_step(0);
        model_step(1);
        q_start = start_btn; q_pause = pause_btn; q_ml = miss_l; q_mr = miss_r;
        @(posedge clk);
        #1;
        check("dut0_model", 32'(got_vec(0)), 32'(exp_vec(0)));
        check("dut1_model", 32'(got_vec(1)), 32'(exp_vec(1)));
    endtask

    initial begin
        reset = 1; frame_tick = 0; start_btn = 0; pause_btn = 0; miss_l = 0; miss_r = 0;
        model_reset();
        #12;
        check("reset_state", 32'(st[0]), 0);
        check("reset_gra_still", 32'(gs[0]), 1);
        check("reset_vec1", 32'(got_vec(1)), 32'(exp_vec(1)));
        check("reset_digits", {16'h0, a1[0], a0[0], b1[0], b0[0]}, 0);
        @(posedge clk); #1;
        reset = 0;

        // Start twice: IDLE -> SERVE -> PLAY with a one-cycle ball_reset
        start_btn = 1; tick();
        check("t1_serve", 32'(st[0]), 1);
        start_btn = 0; tick();
        start_btn = 1; tick();
        check("t1_play", 32'(st[0]), 2);
        check("t1_ball_reset", 32'(br[0]), 1);
        check("t1_gra_still", 32'(gs[0]), 0);
        start_btn = 0; tick();
        check("t1_ball_reset_off", 32'(br[0]), 0);

        // Right miss scores P1, then the point delay
        miss_r = 1; tick();
        check("t2_point", 32'(st[0]), 3);
        check("t2_p1", {24'h0, a1[0], a0[0]}, 32'h01);
        miss_r = 0; frame_tick = 1;
        repeat (DLY0 - 1) tick();
        check("t2_still_point", 32'(st[0]), 3);
        tick();
        check("t2_serve", 32'(st[0]), 1);
        check("t2_serve_dir", 32'(sd[0]), 1);
        frame_tick = 0;

        // Simultaneous misses do nothing
        start_btn = 1; tick(); start_btn = 0; tick();
        miss_l = 1; miss_r = 1; tick();
        check("t4_play", 32'(st[0]), 2);
        check("t4_digits", {16'h0, a1[0], a0[0], b1[0], b0[0]}, 32'h0100);
        miss_l = 0; miss_r = 0; tick();

        // P2 to 4, then the winning point and the game-over delay
        repeat (4) begin
            miss_l = 1; tick(); miss_l = 0;
            frame_tick = 1; repeat (DLY0) tick(); frame_tick = 0;
            start_btn = 1; tick(); start_btn = 0; tick();
        end
        check("t3_p2_four", {24'h0, b1[0], b0[0]}, 32'h04);
        miss_l = 1; tick();
        check("t3_over", 32'(st[0]), 5);
        check("t3_winner", 32'(wn[0]), 2);
        check("t3_p2_five", {24'h0, b1[0], b0[0]}, 32'h05);
        miss_l = 0; frame_tick = 1;
        repeat (DLY0 - 1) tick();
        frame_tick = 0;
        start_btn = 1; tick();
        check("t3_early_start", 32'(st[0]), 5);
        start_btn = 0; frame_tick = 1; tick(); frame_tick = 0; tick();
        start_btn = 1; tick();
        check("t3_idle", 32'(st[0]), 0);
        check("t3_cleared", {14'h0, wn[0], a1[0], a0[0], b1[0], b0[0]}, 0);
        start_btn = 0; tick();

        // Pause and miss in the same cycle: the miss wins
        start_btn = 1; tick(); start_btn = 0; tick();
        start_btn = 1; tick(); start_btn = 0; tick();
        pause_btn = 1; miss_r = 1; tick();
        check("t5_miss_over_pause", 32'(st[0]), 3);
        pause_btn = 0; miss_r = 0; tick();

        // Asynchronous reset in the middle of a point delay
        frame_tick = 1; repeat (60) tick(); frame_tick = 0;
        #2;
        reset = 1;
        #1;
        check("t6_reset_state", 32'(st[0]), 0);
        check("t6_reset_digits", {16'h0, a1[0], a0[0], b1[0], b0[0]}, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;

        // Random play
        for (int i = 0; i < 30000; i++) begin
            start_btn  = ($urandom_range(0, 2) == 0);
            pause_btn  = ($urandom_range(0, 15) == 0);
            miss_l     = ($urandom_range(0, 9) == 0);
            miss_r     = ($urandom_range(0, 9) == 0);
            frame_tick = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
